// File: rtl/pwm_multi.sv
// ---------------------------------------------------------------------------
// pwm_multi
//
// Multi-channel PWM generator for the motor driver pins. All channels share
// one prescaler and one step counter. Each channel has a pending duty register
// and an active duty register. Period and mode are double-buffered the same
// way. Pending values move to the active registers only at a period boundary,
// or on every clock while disabled, so a running waveform never glitches.
//
// Ports:
//   clk           system clock
//   clr_n         synchronous active-low reset
//   en            run enable; low holds the counter at zero and forces outputs low
//   prescale      clocks per step minus one (live value, not buffered)
//   period        steps per period P (buffered)
//   mode          0 edge-aligned, 1 center-aligned (buffered with period)
//   cfg_wr        load period/mode into the pending registers
//   duty          packed per-channel duty, channel i at [i*DUTY_BITS +: DUTY_BITS]
//   duty_wr       per-channel load of the pending duty
//   out           registered PWM outputs
//   period_start  one-clock pulse on the first clock of each period
//   duty_pending  per-channel flag: a written duty has not been applied yet
// ---------------------------------------------------------------------------
module pwm_multi #(
   parameter int CHANNELS      = 4,
   parameter int DUTY_BITS     = 8,
   parameter int PRESCALE_BITS = 17
) (
   input  logic                            clk,
   input  logic                            clr_n,
   input  logic                            en,
   input  logic [PRESCALE_BITS-1:0]        prescale,
   input  logic [DUTY_BITS-1:0]            period,
   input  logic                            mode,
   input  logic                            cfg_wr,
   input  logic [CHANNELS*DUTY_BITS-1:0]   duty,
   input  logic [CHANNELS-1:0]             duty_wr,
   output logic [CHANNELS-1:0]             out,
   output logic                            period_start,
   output logic [CHANNELS-1:0]             duty_pending
);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   logic [PRESCALE_BITS-1:0] pre;
   logic [PRESCALE_BITS-1:0] pre_n;
   logic [DUTY_BITS-1:0]     cnt;
   logic [DUTY_BITS-1:0]     cnt_n;
   dir_t                     dir;
   dir_t                     dir_n;
   logic                     en_q;

   logic [DUTY_BITS-1:0]     p_pend;
   logic [DUTY_BITS-1:0]     p_act;
   logic                     m_pend;
   logic                     m_act;
   logic [DUTY_BITS-1:0]     dpend [CHANNELS];
   logic [DUTY_BITS-1:0]     dact  [CHANNELS];

   logic                     tick;
   logic                     boundary;
   logic                     load_act;
   logic [DUTY_BITS-1:0]     p_last;
   logic [CHANNELS-1:0]      out_n;
   logic                     ps_n;

   assign p_last = p_act - 1'b1;

   // State register: prescaler, step counter, direction, the double-buffered
   // configuration and the registered outputs. While disabled (or at a period
   // boundary) the active registers take the pending values. A write in the
   // same clock still lands in pending and keeps its pending flag set, so it
   // applies at the following boundary.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         pre          <= '0;
         cnt          <= '0;
         dir          <= DIR_UP;
         en_q         <= 1'b0;
         p_pend       <= '0;
         p_act        <= '0;
         m_pend       <= 1'b0;
         m_act        <= 1'b0;
         out          <= '0;
         period_start <= 1'b0;
         duty_pending <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            dpend[i] <= '0;
            dact[i]  <= '0;
         end
      end else begin
         pre          <= pre_n;
         cnt          <= cnt_n;
         dir          <= dir_n;
         en_q         <= en;
         out          <= out_n;
         period_start <= ps_n;
         if (cfg_wr) begin
            p_pend <= period;
            m_pend <= mode;
         end
         if (load_act) begin
            p_act <= p_pend;
            m_act <= m_pend;
         end
         for (int i = 0; i < CHANNELS; i++) begin
            if (load_act) begin
               dact[i] <= dpend[i];
            end
            if (duty_wr[i]) begin
               dpend[i]        <= duty[i*DUTY_BITS +: DUTY_BITS];
               duty_pending[i] <= 1'b1;
            end else if (load_act) begin
               duty_pending[i] <= 1'b0;
            end
         end
      end
   end

   // Next-state logic for the prescaler and the step counter. Edge mode counts
   // 0..P-1 and wraps. Center mode counts up to P-1, holds one extra step while
   // turning down, counts back to 0 and holds one extra step while turning up;
   // that second turnaround is the period boundary. With P=0 the counter stays
   // at zero but every tick is a boundary so a new period can still load.
   always_comb begin
      tick     = (pre >= prescale);
      pre_n    = pre;
      cnt_n    = cnt;
      dir_n    = dir;
      boundary = 1'b0;
      if (!en) begin
         pre_n = '0;
         cnt_n = '0;
         dir_n = DIR_UP;
      end else begin
         pre_n = tick ? '0 : pre + 1'b1;
         if (tick) begin
            if (p_act == '0) begin
               boundary = 1'b1;
               cnt_n    = '0;
               dir_n    = DIR_UP;
            end else if (!m_act) begin
               if (cnt == p_last) begin
                  boundary = 1'b1;
                  cnt_n    = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end else if (dir == DIR_UP) begin
               if (cnt == p_last) begin
                  dir_n = DIR_DOWN;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end else begin
               if (cnt == '0) begin
                  dir_n    = DIR_UP;
                  boundary = 1'b1;
               end else begin
                  cnt_n = cnt - 1'b1;
               end
            end
         end
      end
      load_act = !en || boundary;
   end

   // Output logic. Outputs compare the current count against the active duty,
   // so duty 0 is constantly low and duty >= P is constantly high. The period
   // pulse fires at a boundary and on the first clock after enable rises.
   always_comb begin
      out_n = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         out_n[i] = en && (p_act != '0) && (cnt < dact[i]);
      end
      ps_n = en && (!en_q || boundary);
   end

endmodule

// File: tb/tb_pwm_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi
//
// Bench for pwm_multi. A behavioural model tracks the position inside the
// period as a step index and derives the counter from it. Each driven clock
// pushes the expected outputs to a queue, and the scenario tasks pop and
// compare them once the DUT has registered its outputs. A few scenarios also
// count high cycles over whole periods against fixed numbers.
// ---------------------------------------------------------------------------
module tb_pwm_multi;

   localparam int CH = 4;
   localparam int DB = 8;
   localparam int PB = 17;

   logic              clk = 1'b0;
   logic              clr_n;
   logic              en;
   logic [PB-1:0]     prescale;
   logic [DB-1:0]     period;
   logic              mode;
   logic              cfg_wr;
   logic [CH*DB-1:0]  duty;
   logic [CH-1:0]     duty_wr;
   logic [CH-1:0]     out;
   logic              period_start;
   logic [CH-1:0]     duty_pending;

   typedef struct packed {
      logic [CH-1:0] o;
      logic          ps;
      logic [CH-1:0] pd;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   int      m_pre;
   int      m_step;
   int      m_pact;
   bit      m_mact;
   int      m_ppend;
   bit      m_mpend;
   int      m_dpend [CH];
   int      m_dact  [CH];
   bit [CH-1:0] m_flag;
   bit      m_enq;

   pwm_multi #(
      .CHANNELS      (CH),
      .DUTY_BITS     (DB),
      .PRESCALE_BITS (PB)
   ) dut (
      .clk          (clk),
      .clr_n        (clr_n),
      .en           (en),
      .prescale     (prescale),
      .period       (period),
      .mode         (mode),
      .cfg_wr       (cfg_wr),
      .duty         (duty),
      .duty_wr      (duty_wr),
      .out          (out),
      .period_start (period_start),
      .duty_pending (duty_pending)
   );

   always #5 clk = ~clk;

   // Advance the model by one clock using the inputs currently driven and
   // queue the outputs the DUT should show after that clock edge.
   task automatic model_step();
      exp_t e;
      int   len;
      int   c;
      bit   tick;
      bit   bnd;
      bit   load;
      e = '0;
      if (!clr_n) begin
         m_pre = 0; m_step = 0; m_pact = 0; m_mact = 0; m_ppend = 0; m_mpend = 0;
         m_flag = '0; m_enq = 0;
         for (int i = 0; i < CH; i++) begin
            m_dpend[i] = 0;
            m_dact[i]  = 0;
         end
      end else begin
         len  = (m_pact == 0) ? 1 : (m_mact ? 2 * m_pact : m_pact);
         c    = (m_pact == 0) ? 0 :
                ((!m_mact || m_step < m_pact) ? m_step : 2 * m_pact - 1 - m_step);
         tick = en && (m_pre >= int'(prescale));
         bnd  = tick && (m_step == len - 1);
         load = !en || bnd;
         for (int i = 0; i < CH; i++) begin
            e.o[i] = en && (m_pact != 0) && (c < m_dact[i]);
         end
         e.ps = en && (!m_enq || bnd);
         if (!en) begin
            m_pre  = 0;
            m_step = 0;
         end else begin
            m_pre = tick ? 0 : m_pre + 1;
            if (tick) m_step = bnd ? 0 : m_step + 1;
         end
         if (load) begin
            m_pact = m_ppend;
            m_mact = m_mpend;
            for (int i = 0; i < CH; i++) m_dact[i] = m_dpend[i];
         end
         if (cfg_wr) begin
            m_ppend = int'(period);
            m_mpend = mode;
         end
         for (int i = 0; i < CH; i++) begin
            if (duty_wr[i]) begin
               m_dpend[i] = int'(duty[i*DB +: DB]);
               m_flag[i]  = 1'b1;
            end else if (load) begin
               m_flag[i] = 1'b0;
            end
         end
         e.pd  = m_flag;
         m_enq = en;
      end
      exp_q.push_back(e);
   endtask

   // Drive one clock: queue the expectation, then let the edge happen and
   // settle just after it so outputs are sampled away from the edge.
   task automatic apply_stimulus();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      exp_t got;
      clr_n = 1'b0; en = 1'b1; prescale = '0; period = '0; mode = 1'b0;
      cfg_wr = 1'b0; duty = '0; duty_wr = '0;
      for (int k = 0; k < 20; k++) begin
         apply_stimulus();
         e = exp_q.pop_front();
         got = {out, period_start, duty_pending};
         checks++;
         if (got !== e) begin
            errors++;
            $display("[TB] FAIL reset cycle %0d got out=%b ps=%b pend=%b exp out=%b ps=%b pend=%b",
                     k, got.o, got.ps, got.pd, e.o, e.ps, e.pd);
         end
      end
      checks++;
      if ({out, period_start, duty_pending} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_zero got %b exp 0", {out, period_start, duty_pending});
      end
   endtask

   task automatic test_edge();
      exp_t e;
      exp_t got;
      int   h[CH];
      int   ps_cnt;
      ps_cnt = 0;
      for (int i = 0; i < CH; i++) h[i] = 0;
      clr_n = 1'b1; en = 1'b0; prescale = '0; period = 8'd10; mode = 1'b0;
      cfg_wr = 1'b1; duty = {8'd15, 8'd10, 8'd0, 8'd3}; duty_wr = 4'hf;
      for (int k = 0; k < 50; k++) begin
         if (k == 1) begin cfg_wr = 1'b0; duty_wr = '0; end
         if (k == 2) en = 1'b1;
         apply_stimulus();
         e = exp_q.pop_front();
         got = {out, period_start, duty_pending};
         checks++;
         if (got !== e) begin
            errors++;
            $display("[TB] FAIL edge cycle %0d got out=%b ps=%b pend=%b exp out=%b ps=%b pend=%b",
                     k, got.o, got.ps, got.pd, e.o, e.ps, e.pd);
         end
         if (k >= 40) begin
            for (int i = 0; i < CH; i++) h[i] += int'(out[i]);
            ps_cnt += int'(period_start);
         end
      end
      checks++;
      if (h[0] != 3) begin errors++; $display("[TB] FAIL edge_out0_width got %0d exp 3", h[0]); end
      checks++;
      if (h[1] != 0) begin errors++; $display("[TB] FAIL edge_out1_zero got %0d exp 0", h[1]); end
      checks++;
      if (h[2] != 10) begin errors++; $display("[TB] FAIL edge_out2_full got %0d exp 10", h[2]); end
      checks++;
      if (h[3] != 10) begin errors++; $display("[TB] FAIL edge_out3_over got %0d exp 10", h[3]); end
      checks++;
      if (ps_cnt != 1) begin errors++; $display("[TB] FAIL edge_ps_count got %0d exp 1", ps_cnt); end
   endtask

   task automatic test_prescale();
      exp_t e;
      exp_t got;
      int   h0;
      int   ps_cnt;
      h0 = 0; ps_cnt = 0;
      prescale = 17'd4;
      for (int k = 0; k < 160; k++) begin
         apply_stimulus();
         e = exp_q.pop_front();
         got = {out, period_start, duty_pending};
         checks++;
         if (got !== e) begin
            errors++;
            $display("[TB] FAIL prescale cycle %0d got out=%b ps=%b pend=%b exp out=%b ps=%b pend=%b",
                     k, got.o, got.ps, got.pd, e.o, e.ps, e.pd);
         end
         if (k >= 60) begin
            h0 += int'(out[0]);
            ps_cnt += int'(period_start);
         end
      end
      checks++;
      if (h0 != 30) begin errors++; $display("[TB] FAIL prescale_out0_width got %0d exp 30", h0); end
      checks++;
      if (ps_cnt != 2) begin errors++; $display("[TB] FAIL prescale_ps_count got %0d exp 2", ps_cnt); end
   endtask

   task automatic test_center();
      exp_t e;
      exp_t got;
      int   h0;
      int   ps_cnt;
      h0 = 0; ps_cnt = 0;
      en = 1'b0; prescale = '0; period = 8'd8; mode = 1'b1; cfg_wr = 1'b1;
      duty = {8'd15, 8'd10, 8'd0, 8'd2}; duty_wr = 4'h1;
      for (int k = 0; k < 60; k++) begin
         if (k == 1) begin cfg_wr = 1'b0; duty_wr = '0; end
         if (k == 2) en = 1'b1;
         apply_stimulus();
         e = exp_q.pop_front();
         got = {out, period_start, duty_pending};
         checks++;
         if (got !== e) begin
            errors++;
            $display("[TB] FAIL center cycle %0d got out=%b ps=%b pend=%b exp out=%b ps=%b pend=%b",
                     k, got.o, got.ps, got.pd, e.o, e.ps, e.pd);
         end
         if (k >= 28) begin
            h0 += int'(out[0]);
            ps_cnt += int'(period_start);
         end
      end
      checks++;
      if (h0 != 8) begin errors++; $display("[TB] FAIL center_out0_width got %0d exp 8", h0); end
      checks++;
      if (ps_cnt != 2) begin errors++; $display("[TB] FAIL center_ps_count got %0d exp 2", ps_cnt); end
   endtask

   task automatic test_duty_update();
      exp_t e;
      exp_t got;
      bit   bwrote;
      int   wr_k;
      bwrote = 1'b0; wr_k = -10;
      en = 1'b0; prescale = '0; period = 8'd10; mode = 1'b0; cfg_wr = 1'b1;
      duty = {8'd15, 8'd10, 8'd0, 8'd3}; duty_wr = 4'h1;
      for (int k = 0; k < 100; k++) begin
         if (k == 1) begin cfg_wr = 1'b0; duty_wr = '0; end
         if (k == 2) en = 1'b1;
         if (k == 15) begin duty[DB-1:0] = 8'd7; duty_wr = 4'h1; end
         if (k == 16) duty_wr = '0;
         if (k == wr_k + 1) duty_wr = '0;
         if (!bwrote && k >= 40 && m_step == m_pact - 1) begin
            duty[DB-1:0] = 8'd3; duty_wr = 4'h1; bwrote = 1'b1; wr_k = k;
         end
         apply_stimulus();
         e = exp_q.pop_front();
         got = {out, period_start, duty_pending};
         checks++;
         if (got !== e) begin
            errors++;
            $display("[TB] FAIL duty_update cycle %0d got out=%b ps=%b pend=%b exp out=%b ps=%b pend=%b",
                     k, got.o, got.ps, got.pd, e.o, e.ps, e.pd);
         end
         if (k == 15 || k == wr_k) begin
            checks++;
            if (duty_pending[0] !== 1'b1) begin
               errors++;
               $display("[TB] FAIL pending_after_write cycle %0d got %b exp 1", k, duty_pending[0]);
            end
         end
      end
      checks++;
      if (!bwrote) begin
         errors++;
         $display("[TB] FAIL boundary_write_found got 0 exp 1");
      end
   endtask

   task automatic test_enable();
      exp_t e;
      exp_t got;
      for (int k = 0; k < 60; k++) begin
         if (k == 5) en = 1'b0;
         if (k == 6) begin duty[DB-1:0] = 8'd5; duty_wr = 4'h1; end
         if (k == 7) duty_wr = '0;
         if (k == 10) en = 1'b1;
         apply_stimulus();
         e = exp_q.pop_front();
         got = {out, period_start, duty_pending};
         checks++;
         if (got !== e) begin
            errors++;
            $display("[TB] FAIL enable cycle %0d got out=%b ps=%b pend=%b exp out=%b ps=%b pend=%b",
                     k, got.o, got.ps, got.pd, e.o, e.ps, e.pd);
         end
         if (k == 5) begin
            checks++;
            if (out !== '0) begin errors++; $display("[TB] FAIL disable_out got %b exp 0000", out); end
         end
         if (k == 10) begin
            checks++;
            if (period_start !== 1'b1) begin
               errors++;
               $display("[TB] FAIL enable_ps got %b exp 1", period_start);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      exp_t got;
      for (int k = 0; k < 25; k++) begin
         clr_n = (k != 7);
         apply_stimulus();
         e = exp_q.pop_front();
         got = {out, period_start, duty_pending};
         checks++;
         if (got !== e) begin
            errors++;
            $display("[TB] FAIL mid_reset cycle %0d got out=%b ps=%b pend=%b exp out=%b ps=%b pend=%b",
                     k, got.o, got.ps, got.pd, e.o, e.ps, e.pd);
         end
         if (k == 7) begin
            checks++;
            if ({out, period_start, duty_pending} !== '0) begin
               errors++;
               $display("[TB] FAIL mid_reset_zero got %b exp 0", {out, period_start, duty_pending});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_edge();
      test_prescale();
      test_center();
      test_duty_update();
      test_enable();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
